dvi_mmcm_drp_ctrl: RTL and testbench

//  Runtime reconfiguration controller for the DVI TX MMCM via its DRP port.
//  - On a mode request, holds the MMCM in reset and fetches the mode's register table from an external ROM.
//  - Performs a DRP read-modify-write per entry, releases reset, waits for lock, then reports done.
//  - Handles power-on reset sequencing and relock after lock loss.
//  - Runs in the 125 MHz reference clock domain, which also drives MMCM DCLK.

---
 rtl/dvi_mmcm_drp_ctrl_if.sv | 40 ++++
 rtl/dvi_mmcm_drp_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dvi_mmcm_drp_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvi_mmcm_drp_ctrl_if.sv
// ============================================================================
// Module   : dvi_mmcm_drp_ctrl_if
// Brief    : Config handshake, mode-table ROM and MMCM DRP signals of the
//            DVI MMCM reconfiguration controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dvi_mmcm_drp_ctrl_if #(
  parameter int MODE_W = 2,
  parameter int ROM_AW = 7
);
  logic              i_cfg_req;
  logic [MODE_W-1:0] i_cfg_mode;
  logic              o_cfg_busy;
  logic              o_cfg_done;
  logic              o_cfg_err;
  logic [ROM_AW-1:0] o_rom_addr;
  logic [38:0]       i_rom_data;
  logic [6:0]        o_daddr;
  logic [15:0]       o_di;
  logic              o_den;
  logic              o_dwe;
  logic [15:0]       i_do;
  logic              i_drdy;

  modport master (
    input  i_cfg_req, i_cfg_mode, i_rom_data, i_do, i_drdy,
    output o_cfg_busy, o_cfg_done, o_cfg_err, o_rom_addr,
           o_daddr, o_di, o_den, o_dwe
  );

  modport slave (
    output i_cfg_req, i_cfg_mode, i_rom_data, i_do, i_drdy,
    input  o_cfg_busy, o_cfg_done, o_cfg_err, o_rom_addr,
           o_daddr, o_di, o_den, o_dwe
  );
endinterface

`default_nettype wire

// File: rtl/dvi_mmcm_drp_ctrl.sv
// ============================================================================
// Module   : dvi_mmcm_drp_ctrl
// Brief    : DVI TX MMCM runtime reconfiguration over DRP (read-modify-write
//            of a ROM mode table), reset sequencing and relock handling.
//            Optional: DVI_DRP_LOCK_TIMEOUT_EN bounds the wait for lock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dvi_mmcm_drp_ctrl #(
  parameter int NUM_REGS     = 23,
  parameter int NUM_MODES    = 4,
  parameter int MODE_W       = 2,
  parameter int ROM_AW       = 7,
  parameter int RST_CYCLES   = 4,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 2**20
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  dvi_mmcm_drp_ctrl_if.master   bus,
  output logic                  o_mmcm_rst,
  input  logic                  i_mmcm_locked,
  output logic                  o_locked
);

  localparam int c_IDX_W   = $clog2(NUM_REGS);
  localparam int c_CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_REL_RST, S_WAIT_LOCK, S_IDLE, S_RST_HOLD, S_ROM_RD, S_ROM_WAIT,
    S_DRP_RD, S_RD_WAIT, S_DRP_WR, S_WR_WAIT, S_DONE
  } state_t;

  state_t               r_state, w_next;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]   r_idx;
  logic [ROM_AW-1:0]    r_rom_addr;
  logic [15:0]          r_mask, r_data, r_di;
  logic [6:0]           r_daddr;
  logic                 r_den, r_dwe, r_busy, r_done, r_err, r_mmcm_rst;
  logic                 r_lock_meta, r_lock_sync;
  logic                 w_accept, w_bad_mode, w_abort, w_mode_ok, w_last, w_cnt_clr;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= i_mmcm_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  assign w_mode_ok = ({1'b0, bus.i_cfg_mode} < (MODE_W+1)'(NUM_MODES));
  assign w_last    = (r_idx == c_IDX_W'(NUM_REGS - 1));

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) r_state <= S_REL_RST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_bad_mode = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      S_REL_RST:   if (r_cnt == c_CNT_W'(RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (r_lock_sync) w_next = r_busy ? S_DONE : S_IDLE;
`ifdef DVI_DRP_LOCK_TIMEOUT_EN
        else if (r_cnt == c_CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_next  = S_REL_RST;
          w_abort = 1'b1;
        end
`endif
      end
      S_IDLE: begin
        if (!r_lock_sync) w_next = S_REL_RST;
        else if (bus.i_cfg_req) begin
          if (w_mode_ok) begin
            w_accept = 1'b1;
            w_next   = S_RST_HOLD;
          end else begin
            w_bad_mode = 1'b1;
          end
        end
      end
      S_RST_HOLD:  w_next = S_ROM_RD;
      S_ROM_RD:    w_next = S_ROM_WAIT;
      S_ROM_WAIT:  w_next = S_DRP_RD;
      S_DRP_RD:    w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.i_drdy) w_next = S_DRP_WR;
        else if (r_cnt == c_CNT_W'(DRDY_TIMEOUT - 1)) begin
          w_next  = S_REL_RST;
          w_abort = 1'b1;
        end
      end
      S_DRP_WR:    w_next = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.i_drdy) w_next = w_last ? S_REL_RST : S_ROM_RD;
        else if (r_cnt == c_CNT_W'(DRDY_TIMEOUT - 1)) begin
          w_next  = S_REL_RST;
          w_abort = 1'b1;
        end
      end
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_REL_RST;
    endcase
  end

  // The DRDY timeout runs from the o_den cycle, so the counter is not cleared
  // on the DRP_RD->RD_WAIT and DRP_WR->WR_WAIT steps.
  assign w_cnt_clr = (w_next != r_state) && (r_state != S_DRP_RD) && (r_state != S_DRP_WR);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      r_di       <= '0;
      r_daddr    <= '0;
      r_den      <= 1'b0;
      r_dwe      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_mmcm_rst <= 1'b1;
    end else begin
      r_cnt      <= w_cnt_clr ? '0 : r_cnt + c_CNT_W'(1);
      r_mmcm_rst <= !((w_next == S_WAIT_LOCK) || (w_next == S_IDLE) || (w_next == S_DONE));
      r_den      <= (w_next == S_DRP_RD) || (w_next == S_DRP_WR);
      r_dwe      <= (w_next == S_DRP_WR);
      r_done     <= (w_next == S_DONE);
      if (w_accept) begin
        r_busy     <= 1'b1;
        r_err      <= 1'b0;
        r_idx      <= '0;
        r_rom_addr <= ROM_AW'(bus.i_cfg_mode) * ROM_AW'(NUM_REGS);
      end
      if (w_bad_mode || w_abort) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
      end
      if (w_next == S_DONE) r_busy <= 1'b0;
      if (r_state == S_ROM_WAIT) begin
        r_daddr <= bus.i_rom_data[38:32];
        r_mask  <= bus.i_rom_data[31:16];
        r_data  <= bus.i_rom_data[15:0];
      end
      // Mask bit set keeps the bit read back from the MMCM.
      if ((r_state == S_RD_WAIT) && bus.i_drdy) r_di <= (bus.i_do & r_mask) | (r_data & ~r_mask);
      if ((r_state == S_WR_WAIT) && bus.i_drdy && !w_last) begin
        r_idx      <= r_idx + c_IDX_W'(1);
        r_rom_addr <= r_rom_addr + ROM_AW'(1);
      end
    end
  end

  assign bus.o_cfg_busy = r_busy;
  assign bus.o_cfg_done = r_done;
  assign bus.o_cfg_err  = r_err;
  assign bus.o_rom_addr = r_rom_addr;
  assign bus.o_daddr    = r_daddr;
  assign bus.o_di       = r_di;
  assign bus.o_den      = r_den;
  assign bus.o_dwe      = r_dwe;
  assign o_mmcm_rst     = r_mmcm_rst;
  assign o_locked       = (r_state == S_IDLE) && r_lock_sync;

endmodule

`default_nettype wire

// File: tb/tb_dvi_mmcm_drp_ctrl.sv
// ============================================================================
// Module   : tb_dvi_mmcm_drp_ctrl
// Brief    : Scoreboard bench for dvi_mmcm_drp_ctrl with ROM, DRP and MMCM
//            lock models; DVI_DRP_LOCK_TIMEOUT_EN adds the lock-timeout case.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dvi_mmcm_drp_ctrl;
  localparam int NUM_REGS  = 23;
  localparam int NUM_MODES = 3;
  localparam int MODE_W    = 2;
  localparam int ROM_AW    = 7;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic mmcm_rst, mmcm_locked, locked;

  always #4 clk = ~clk;

  dvi_mmcm_drp_ctrl_if #(.MODE_W(MODE_W), .ROM_AW(ROM_AW)) bus ();

  dvi_mmcm_drp_ctrl #(
    .NUM_REGS(NUM_REGS), .NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .ROM_AW(ROM_AW),
    .RST_CYCLES(4), .DRDY_TIMEOUT(255), .LOCK_TIMEOUT(1000)
  ) dut (
    .i_clk(clk), .i_arst(arst), .bus(bus), .o_mmcm_rst(mmcm_rst),
    .i_mmcm_locked(mmcm_locked), .o_locked(locked)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", nm);
  endtask

  function automatic logic [38:0] rom_word(input int m, input int i);
    logic [15:0] mask, data;
    mask = 16'h1000 ^ 16'(i * 16'h0421) ^ 16'(m * 16'h0088) ^ 16'h0088;
    data = 16'(16'h0145 + i * 16'h0111 + m * 16'h3000 - 16'h3000);
    return {7'(8 + i), mask, data};
  endfunction

  always @(posedge clk) cyc++;

  // Registered ROM: data valid one cycle after the address.
  logic [38:0] rom [0:127];
  always @(posedge clk) bus.i_rom_data <= rom[bus.o_rom_addr];

  logic [15:0] drp_mem [0:127];
  int          drp_lat = 3;
  bit          stall_en = 1'b0;
  bit          pend = 1'b0;
  int          pcnt = 0;
  logic        pwe;
  logic [6:0]  paddr;
  logic [15:0] pdi;

  always @(negedge clk) begin
    bus.i_drdy = 1'b0;
    if (pend) begin
      if (pcnt <= 1) begin
        bus.i_drdy = 1'b1;
        bus.i_do   = drp_mem[paddr];
        if (pwe) drp_mem[paddr] = pdi;
        pend = 1'b0;
      end else begin
        pcnt--;
      end
    end
    if (!arst && bus.o_den) begin
      if (pend) flag("den_before_drdy");
      else if (!(stall_en && !bus.o_dwe && bus.o_daddr == 7'd13)) begin
        pend  = 1'b1;
        pcnt  = drp_lat;
        paddr = bus.o_daddr;
        pwe   = bus.o_dwe;
        pdi   = bus.o_di;
      end
    end
  end

  int lk_cnt   = 0;
  bit withhold = 1'b0;
  bit kick     = 1'b0;

  always @(negedge clk) begin
    if (mmcm_rst || withhold || kick) begin
      mmcm_locked = 1'b0;
      lk_cnt      = 0;
      kick        = 1'b0;
    end else if (lk_cnt >= 100) begin
      mmcm_locked = 1'b1;
    end else begin
      lk_cnt++;
    end
  end

  logic [22:0] wr_q [$];
  logic [6:0]  rd_q [$];
  int          done_q [$];
  int          n_wr = 0;
  bit          first_seen = 1'b0;
  logic [22:0] first_wr = '0;
  logic [22:0] mon_e;
  int          stall_cyc = -1;

  always @(negedge clk) begin
    if (!arst) begin
      if (bus.o_den) begin
        check("rst_held_during_drp", mmcm_rst, 1);
        if (bus.o_dwe) begin
          n_wr++;
          if (!first_seen) begin
            first_seen = 1'b1;
            first_wr   = {bus.o_daddr, bus.o_di};
          end
          if (wr_q.size() == 0) flag("unexpected_write");
          else begin
            mon_e = wr_q.pop_front();
            check("drp_write", {bus.o_daddr, bus.o_di}, mon_e);
          end
        end else begin
          if (bus.o_daddr == 7'd13) stall_cyc = cyc;
          if (rd_q.size() == 0) flag("unexpected_read");
          else check("drp_read_addr", bus.o_daddr, rd_q.pop_front());
        end
      end
      if (bus.o_cfg_done) begin
        if (done_q.size() == 0) flag("unexpected_done");
        else begin
          void'(done_q.pop_front());
          check("done_without_err", bus.o_cfg_err, 0);
        end
      end
    end
  end

  task automatic expect_cfg(input int m, input int n_ent, input bit with_done, input int n_rd);
    logic [38:0] w;
    logic [15:0] di;
    for (int i = 0; i < n_rd; i++) rd_q.push_back(7'(8 + i));
    for (int i = 0; i < n_ent; i++) begin
      w  = rom_word(m, i);
      di = (drp_mem[w[38:32]] & w[31:16]) | (w[15:0] & ~w[31:16]);
      wr_q.push_back({w[38:32], di});
    end
    if (with_done) done_q.push_back(m);
  endtask

  task automatic request(input int m);
    @(negedge clk);
    bus.i_cfg_mode = MODE_W'(m);
    bus.i_cfg_req  = 1'b1;
    @(negedge clk);
    bus.i_cfg_req  = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return locked;
      1:       return bus.o_cfg_done;
      2:       return bus.o_cfg_err;
      3:       return !mmcm_rst;
      4:       return bus.o_den && !bus.o_dwe && (bus.o_daddr == 7'd18);
      default: return mmcm_rst;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string nm);
    int k;
    k = 0;
    while (!sig(sel) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(nm, sig(sel), 1);
  endtask

  task automatic count_rst(input string nm);
    int n;
    n = 0;
    repeat (12) begin
      if (mmcm_rst) n++;
      @(negedge clk);
    end
    check(nm, n, 4);
  endtask

  initial begin
    int n;
    int w_start;
    for (int a = 0; a < 128; a++) begin
      rom[a]     = '0;
      drp_mem[a] = 16'hFFFF;
    end
    for (int m = 0; m < NUM_MODES; m++)
      for (int i = 0; i < NUM_REGS; i++) rom[m * NUM_REGS + i] = rom_word(m, i);
    bus.i_cfg_req  = 1'b0;
    bus.i_cfg_mode = '0;
    bus.i_do       = '0;
    bus.i_drdy     = 1'b0;
    mmcm_locked    = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_mmcm_rst", mmcm_rst, 1);
    check("reset_flags", {bus.o_cfg_busy, bus.o_cfg_done, bus.o_cfg_err, bus.o_den, bus.o_dwe, locked}, 0);
    check("reset_bus", {bus.o_rom_addr, bus.o_daddr, bus.o_di}, 0);

    arst = 1'b0;
    count_rst("por_rst_cycles");
    wait_until(0, 300, "por_locked");

    drp_lat = 3;
    expect_cfg(1, NUM_REGS, 1'b1, NUM_REGS);
    first_seen = 1'b0;
    n_wr = 0;
    request(1);
    check("busy_after_accept", bus.o_cfg_busy, 1);
    wait_until(1, 3000, "cfg_done_mode1");
    check("write_count_mode1", n_wr, NUM_REGS);
    check("first_write_mode1", first_wr, {7'h08, 16'h1145});
    @(negedge clk);
    check("busy_after_done", bus.o_cfg_busy, 0);
    check("locked_after_done", locked, 1);

    drp_lat = 1;
    expect_cfg(0, NUM_REGS, 1'b1, NUM_REGS);
    request(0);
    wait_until(1, 3000, "cfg_done_mode0");

    @(negedge clk);
    bus.i_cfg_mode = 2'd3;
    bus.i_cfg_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("bad_mode_err", bus.o_cfg_err, 1);
    check("bad_mode_not_busy", bus.o_cfg_busy, 0);
    check("bad_mode_mmcm_rst", mmcm_rst, 0);
    check("bad_mode_locked", locked, 1);
    bus.i_cfg_req = 1'b0;
    repeat (3) @(negedge clk);
    check("bad_mode_err_sticky", bus.o_cfg_err, 1);

    stall_en  = 1'b1;
    drp_lat   = 2;
    stall_cyc = -1;
    expect_cfg(2, 5, 1'b0, 6);
    request(2);
    check("err_cleared_on_accept", bus.o_cfg_err, 0);
    wait_until(2, 3000, "drdy_timeout_err");
    check("drdy_timeout_cycles", cyc - stall_cyc, 255);
    check("timeout_not_busy", bus.o_cfg_busy, 0);
    stall_en = 1'b0;
    wait_until(0, 500, "relock_after_timeout");
    check("timeout_err_sticky", bus.o_cfg_err, 1);

    @(posedge clk);
    kick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("locked_one_cycle_after_drop", locked, 1);
    @(negedge clk);
    check("locked_two_cycles_after_drop", locked, 0);
    @(negedge clk);
    count_rst("relock_rst_cycles");
    wait_until(0, 300, "relock_after_drop");

    drp_lat = 2;
    expect_cfg(1, NUM_REGS, 1'b1, NUM_REGS);
    request(1);
    wait_until(4, 2000, "reach_entry10");
    #2 arst = 1'b1;
    #1;
    check("arst_den_low", bus.o_den, 0);
    check("arst_mmcm_rst_high", mmcm_rst, 1);
    check("arst_not_busy", bus.o_cfg_busy, 0);
    wr_q.delete();
    rd_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    arst = 1'b0;
    count_rst("arst_rst_cycles");
    wait_until(0, 300, "relock_after_arst");

`ifdef DVI_DRP_LOCK_TIMEOUT_EN
    withhold = 1'b1;
    wait_until(5, 50, "withhold_rel_rst");
    wait_until(3, 50, "withhold_wait_lock");
    w_start = cyc;
    wait_until(2, 1500, "lock_timeout_err");
    check("lock_timeout_cycles", cyc - w_start, 1000);
    check("lock_timeout_retry_rst", mmcm_rst, 1);
    withhold = 1'b0;
    wait_until(0, 1500, "relock_after_lock_timeout");
`else
    w_start = 0;
`endif

    n = wr_q.size() + rd_q.size() + done_q.size() + w_start * 0;
    check("scoreboard_drained", n, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end
endmodule

`default_nettype wire
